// File: rtl/ram_1port_arbiter.sv
// ram_1port_arbiter: round-robin sharing of one single-port RAM between requesters A and B.
// After reset, an optional sweep fills the whole RAM before the arbiter opens.
module ram_1port_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter bit INIT_EN = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_A_Req,
    input  logic             i_A_Wr,
    input  logic [AW-1:0]    i_A_Addr,
    input  logic [WIDTH-1:0] i_A_Wr_Data,
    output logic             o_A_Gnt,
    output logic             o_A_Rd_DV,
    output logic [WIDTH-1:0] o_A_Rd_Data,
    input  logic             i_B_Req,
    input  logic             i_B_Wr,
    input  logic [AW-1:0]    i_B_Addr,
    input  logic [WIDTH-1:0] i_B_Wr_Data,
    output logic             o_B_Gnt,
    output logic             o_B_Rd_DV,
    output logic [WIDTH-1:0] o_B_Rd_Data,
    output logic [AW-1:0]    o_Ram_Addr,
    output logic             o_Ram_Wr_DV,
    output logic [WIDTH-1:0] o_Ram_Wr_Data,
    output logic             o_Ram_Rd_En,
    input  logic             i_Ram_Rd_DV,
    input  logic [WIDTH-1:0] i_Ram_Rd_Data,
    output logic             o_Init_Done
);
    typedef enum logic {INIT, IDLE} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_last_b;
    logic [1:0]      r_own1, r_own2;
    logic            w_xfer, w_wr;
    logic [AW-1:0]   w_addr;
    logic [WIDTH-1:0] w_data;

    // Contention goes to whichever port did not win last
    assign o_A_Gnt     = (r_state == IDLE) && i_A_Req && (!i_B_Req || r_last_b);
    assign o_B_Gnt     = (r_state == IDLE) && i_B_Req && (!i_A_Req || !r_last_b);
    assign w_xfer      = o_A_Gnt || o_B_Gnt;
    assign w_wr        = o_B_Gnt ? i_B_Wr : i_A_Wr;
    assign w_addr      = o_B_Gnt ? i_B_Addr : i_A_Addr;
    assign w_data      = o_B_Gnt ? i_B_Wr_Data : i_A_Wr_Data;
    assign o_Init_Done = (r_state == IDLE);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state       <= INIT_EN ? INIT : IDLE;
            r_cnt         <= '0;
            r_last_b      <= 1'b1;
            r_own1        <= 2'b00;
            r_own2        <= 2'b00;
            o_Ram_Addr    <= '0;
            o_Ram_Wr_DV   <= 1'b0;
            o_Ram_Wr_Data <= '0;
            o_Ram_Rd_En   <= 1'b0;
            o_A_Rd_DV     <= 1'b0;
            o_A_Rd_Data   <= '0;
            o_B_Rd_DV     <= 1'b0;
            o_B_Rd_Data   <= '0;
        end else begin
            // Owner tag travels two stages to line up with the RAM's read latency
            r_own2    <= r_own1;
            o_A_Rd_DV <= i_Ram_Rd_DV && r_own2[0];
            o_B_Rd_DV <= i_Ram_Rd_DV && r_own2[1];
            if (i_Ram_Rd_DV && r_own2[0]) o_A_Rd_Data <= i_Ram_Rd_Data;
            if (i_Ram_Rd_DV && r_own2[1]) o_B_Rd_Data <= i_Ram_Rd_Data;
            if (r_state == INIT) begin
                o_Ram_Wr_DV   <= 1'b1;
                o_Ram_Rd_En   <= 1'b0;
                o_Ram_Addr    <= r_cnt;
                o_Ram_Wr_Data <= INIT_VALUE;
                r_own1        <= 2'b00;
                r_cnt         <= r_cnt + 1'b1;
                if (r_cnt == AW'(DEPTH - 1)) r_state <= IDLE;
            end else begin
                o_Ram_Wr_DV <= w_xfer && w_wr;
                o_Ram_Rd_En <= w_xfer && !w_wr;
                r_own1      <= (w_xfer && !w_wr) ? {o_B_Gnt, o_A_Gnt} : 2'b00;
                if (w_xfer) begin
                    o_Ram_Addr    <= w_addr;
                    o_Ram_Wr_Data <= w_data;
                    r_last_b      <= o_B_Gnt;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_1port_arbiter.sv
// tb_ram_1port_arbiter: directed and randomized checks of the arbiter against a
// memory-array / read-queue reference model, with a behavioural RAM attached.
module tb_ram_1port_arbiter;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam logic [WIDTH-1:0] INIT_V = 16'hA5A5;

    typedef struct {
        int               due;
        logic             own_b;
        logic [WIDTH-1:0] data;
    } rd_t;

    logic i_Clk = 1'b0;
    logic i_Rst_L = 1'b0;
    logic a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [WIDTH-1:0] a_wd = '0, b_wd = '0;
    logic a_gnt, a_dv, b_gnt, b_dv, ram_wr_dv, ram_rd_en, init_done;
    logic [WIDTH-1:0] a_rd, b_rd, ram_wd;
    logic [AW-1:0] ram_addr;

    logic [WIDTH-1:0] ram [DEPTH];
    logic ram_rd_dv = 1'b0;
    logic [WIDTH-1:0] ram_rd_data = '0;

    logic rst0 = 1'b0, a_req0 = 0;
    logic a_gnt0, a_dv0, b_gnt0, b_dv0, wr_dv0, rd_en0, init_done0;
    logic [WIDTH-1:0] a_rd0, b_rd0, wd0;
    logic [AW-1:0] addr0;

    int passed = 0, total = 0, edge_n = 0, sweep_n = 0;
    logic last_b = 1'b1;
    logic [WIDTH-1:0] mref [DEPTH];
    rd_t pend [$];
    logic exp_wr = 0, exp_rd = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [WIDTH-1:0] exp_wd = '0, exp_ad = '0, exp_bd = '0;

    always #5 i_Clk = ~i_Clk;

    ram_1port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_EN(1'b1), .INIT_VALUE(INIT_V)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L),
        .i_A_Req(a_req), .i_A_Wr(a_wr), .i_A_Addr(a_addr), .i_A_Wr_Data(a_wd),
        .o_A_Gnt(a_gnt), .o_A_Rd_DV(a_dv), .o_A_Rd_Data(a_rd),
        .i_B_Req(b_req), .i_B_Wr(b_wr), .i_B_Addr(b_addr), .i_B_Wr_Data(b_wd),
        .o_B_Gnt(b_gnt), .o_B_Rd_DV(b_dv), .o_B_Rd_Data(b_rd),
        .o_Ram_Addr(ram_addr), .o_Ram_Wr_DV(ram_wr_dv), .o_Ram_Wr_Data(ram_wd),
        .o_Ram_Rd_En(ram_rd_en), .i_Ram_Rd_DV(ram_rd_dv), .i_Ram_Rd_Data(ram_rd_data),
        .o_Init_Done(init_done)
    );

    ram_1port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_EN(1'b0), .INIT_VALUE(INIT_V)) dut0 (
        .i_Clk(i_Clk), .i_Rst_L(rst0),
        .i_A_Req(a_req0), .i_A_Wr(1'b0), .i_A_Addr(4'd2), .i_A_Wr_Data('0),
        .o_A_Gnt(a_gnt0), .o_A_Rd_DV(a_dv0), .o_A_Rd_Data(a_rd0),
        .i_B_Req(1'b0), .i_B_Wr(1'b0), .i_B_Addr('0), .i_B_Wr_Data('0),
        .o_B_Gnt(b_gnt0), .o_B_Rd_DV(b_dv0), .o_B_Rd_Data(b_rd0),
        .o_Ram_Addr(addr0), .o_Ram_Wr_DV(wr_dv0), .o_Ram_Wr_Data(wd0),
        .o_Ram_Rd_En(rd_en0), .i_Ram_Rd_DV(1'b0), .i_Ram_Rd_Data('0),
        .o_Init_Done(init_done0)
    );

    // Single-port RAM: registered read, read-before-write
    always @(posedge i_Clk) begin
        ram_rd_dv <= ram_rd_en;
        if (ram_rd_en) ram_rd_data <= ram[ram_addr];
        if (ram_wr_dv) ram[ram_addr] <= ram_wd;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        logic ga, gb, wr, ea, eb;
        logic [AW-1:0] ad;
        logic [WIDTH-1:0] wd;
        rd_t r;
        #1;
        ga = (sweep_n >= DEPTH) && a_req && (!b_req || last_b);
        gb = (sweep_n >= DEPTH) && b_req && (!a_req || !last_b);
        wr = gb ? b_wr : a_wr;
        ad = gb ? b_addr : a_addr;
        wd = gb ? b_wd : a_wd;
        chk("gnt_a", a_gnt, ga);
        chk("gnt_b", b_gnt, gb);
        chk("init_done", init_done, sweep_n >= DEPTH);
        @(posedge i_Clk);
        edge_n++;
        if (sweep_n < DEPTH) begin
            mref[sweep_n] = INIT_V;
            exp_addr = AW'(sweep_n);
            exp_wd = INIT_V;
            exp_wr = 1;
            exp_rd = 0;
            sweep_n++;
        end else if (ga || gb) begin
            last_b = gb;
            exp_addr = ad;
            exp_wd = wd;
            exp_wr = wr;
            exp_rd = !wr;
            if (wr) mref[ad] = wd;
            else pend.push_back('{edge_n + 2, gb, mref[ad]});
        end else begin
            exp_wr = 0;
            exp_rd = 0;
        end
        #1;
        chk("ram_wr_dv", ram_wr_dv, exp_wr);
        chk("ram_rd_en", ram_rd_en, exp_rd);
        chk("ram_addr", ram_addr, exp_addr);
        chk("ram_wr_data", ram_wd, exp_wd);
        ea = 0;
        eb = 0;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            r = pend.pop_front();
            if (r.own_b) begin eb = 1; exp_bd = r.data; end
            else begin ea = 1; exp_ad = r.data; end
        end
        chk("a_rd_dv", a_dv, ea);
        chk("b_rd_dv", b_dv, eb);
        chk("a_rd_data", a_rd, exp_ad);
        chk("b_rd_data", b_rd, exp_bd);
    endtask

    task automatic do_reset();
        i_Rst_L = 0;
        #2;
        pend.delete();
        last_b = 1;
        sweep_n = 0;
        exp_addr = '0;
        exp_wd = '0;
        exp_ad = '0;
        exp_bd = '0;
        chk("rst_wr_dv", ram_wr_dv, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_a_dv", a_dv, 0);
        chk("rst_b_dv", b_dv, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_addr", ram_addr, 0);
        @(posedge i_Clk);
        #2;
        i_Rst_L = 1;
    endtask

    task automatic cmd(logic ar, logic aw, int aa, int ad, logic br, logic bw, int ba, int bd);
        a_req = ar; a_wr = aw; a_addr = AW'(aa); a_wd = WIDTH'(ad);
        b_req = br; b_wr = bw; b_addr = AW'(ba); b_wd = WIDTH'(bd);
        tick();
    endtask

    initial begin
        // INIT_EN=0 instance: open straight after reset
        #7 rst0 = 1;
        @(negedge i_Clk);
        chk("noinit_done", init_done0, 1);
        a_req0 = 1;
        #1 chk("noinit_gnt_a", a_gnt0, 1);
        chk("noinit_gnt_b", b_gnt0, 0);
        @(posedge i_Clk);
        #1 chk("noinit_rd_en", rd_en0, 1);
        chk("noinit_addr", addr0, 2);
        a_req0 = 0;

        // Sweep with no requests, then read everything back
        do_reset();
        for (int i = 0; i < DEPTH; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cmd(1, 0, i, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);

        // Basic write then read-back
        cmd(1, 1, 7, 16'h1234, 0, 0, 0, 0);
        cmd(1, 0, 7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);

        // Routing of back-to-back reads
        cmd(1, 1, 3, 16'h3333, 0, 0, 0, 0);
        cmd(0, 0, 0, 0, 1, 1, 5, 16'h5555);
        cmd(1, 1, 9, 16'h9999, 0, 0, 0, 0);
        cmd(1, 0, 3, 0, 0, 0, 0, 0);
        cmd(0, 0, 0, 0, 1, 0, 5, 0);
        cmd(1, 0, 9, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            cmd($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom,
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom);
        for (int i = 0; i < 3; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);

        // Continuous contention from reset release
        do_reset();
        for (int i = 0; i < DEPTH + 40; i++)
            cmd(1, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom,
                1, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom);
        for (int i = 0; i < 3; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-sweep at counter 6
        do_reset();
        for (int i = 0; i < 6; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset one cycle after an A read handshake: the read must vanish
        cmd(1, 1, 4, 16'hBEEF, 0, 0, 0, 0);
        cmd(1, 0, 4, 0, 0, 0, 0, 0);
        cmd(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);
        cmd(1, 0, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cmd(0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ram_1port_arbiter.md
Name: ram_1port_arbiter

Overview:
- Shares one single-port RAM (shared address, 1-cycle registered read, read-before-write) between two requesters, A and B, using round-robin arbitration.
- After reset, a sequencer fills every RAM location with a constant before opening the arbiter.
- Issues at most one command per cycle to the RAM and routes each read response back to the requester that issued the read.

Parameters:
- WIDTH, 16, data width of the RAM word.
- DEPTH, 256, number of RAM words. Address width AW = $clog2(DEPTH).
- INIT_EN, 1. 1 = run the fill sweep after reset; 0 = go straight to IDLE.
- INIT_VALUE, 0, WIDTH-bit word written to every address during the sweep.

Ports:
- i_Clk  in  1  clock; all logic is on the rising edge.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_A_Req  in  1  requester A has a valid command.
- i_A_Wr  in  1  1 = write, 0 = read.
- i_A_Addr  in  AW  address for A.
- i_A_Wr_Data  in  WIDTH  write data for A.
- o_A_Gnt  out  1  combinational grant; a transfer occurs on any edge where Req and Gnt are both high.
- o_A_Rd_DV  out  1  one-cycle pulse marking A's read data valid.
- o_A_Rd_Data  out  WIDTH  read data for A.
- i_B_Req, i_B_Wr, i_B_Addr, i_B_Wr_Data, o_B_Gnt, o_B_Rd_DV, o_B_Rd_Data: same as the A ports, for requester B.
- o_Ram_Addr  out  AW  RAM shared address.
- o_Ram_Wr_DV  out  1  RAM write strobe.
- o_Ram_Wr_Data  out  WIDTH  RAM write data.
- o_Ram_Rd_En  out  1  RAM read enable.
- i_Ram_Rd_DV  in  1  RAM read-valid, one cycle after Rd_En is sampled.
- i_Ram_Rd_Data  in  WIDTH  RAM read data.
- o_Init_Done  out  1  high once the arbiter is open.

Behaviour:
- Reset values (async, while i_Rst_L=0): all registered outputs 0; init counter 0; round-robin pointer r_Last=B; both read-owner tags cleared. State = INIT if INIT_EN=1, else IDLE.
- Reset asserted mid-sweep or mid-read: in-flight reads are dropped, no Rd_DV pulse reaches either requester, and the sweep restarts from address 0.
- State INIT:
  - Both Gnt are 0.
  - Each cycle registers o_Ram_Wr_DV=1, o_Ram_Addr=counter, o_Ram_Wr_Data=INIT_VALUE; the counter then increments.
  - Exactly DEPTH writes are issued, addresses 0..DEPTH-1 in order.
  - On the edge that issues address DEPTH-1, move to IDLE and set o_Init_Done=1.
- State IDLE / arbitration (o_Init_Done=1):
  - Only A requesting: Gnt_A=1.
  - Only B requesting: Gnt_B=1.
  - Both requesting: grant the requester other than r_Last.
  - Never both Gnt high. Gnt is a function of Req, state and r_Last only, not of Wr/Addr/Data.
  - On a transfer edge: register o_Ram_Addr/o_Ram_Wr_Data from the winner, o_Ram_Wr_DV=Wr, o_Ram_Rd_En=!Wr; set r_Last=winner.
  - Starvation bound: a continuously requesting port waits for at most one transfer of the other port.
- No transfer: o_Ram_Wr_DV=0 and o_Ram_Rd_En=0; o_Ram_Addr and o_Ram_Wr_Data hold their last values.
- Read return path:
  - The owner tag is registered at the transfer edge (k) and copied to a second tag stage at k+1, in step with the RAM.
  - At edge k+2, register o_X_Rd_DV = i_Ram_Rd_DV && (owner==X) and o_X_Rd_Data = i_Ram_Rd_Data.
  - The pulse is high for exactly the cycle between edges k+2 and k+3.
  - Reads issued on consecutive edges return on consecutive cycles, in issue order.
  - A non-owner's Rd_DV stays 0; its Rd_Data holds its previous value.
- Writes produce no response beyond the handshake.
- Read and write to the same address on consecutive transfers: the later read returns the new data. (The RAM is read-before-write only within a single command, and only one command exists per cycle.)

Test Plan:
- Sweep: DEPTH=16, INIT_VALUE=16'hA5A5, no requests → exactly 16 write strobes, addresses 0..15; Gnt low throughout; o_Init_Done rises after the 16th; a later read of every address returns 16'hA5A5.
- Basic: A writes 16'h1234 to address 7, then A reads address 7 → o_A_Rd_DV pulses 2 cycles after the read handshake edge with 16'h1234; o_B_Rd_DV stays 0.
- Contention: A and B request continuously from reset release → first grant A, then B, A, B alternating; every cycle carries a RAM command; no double grant.
- Routing: back-to-back reads A@3, B@5, A@9 with distinct stored data → three consecutive Rd_DV pulses, A, B, A, each carrying the data of its own address.
- Asynchronous reset: pulse i_Rst_L low mid-sweep (counter=6), and separately one cycle after an A read handshake → sweep restarts at address 0; no Rd_DV pulse is observed for the dropped read.
- INIT_EN=0: o_Init_Done=1 on the first cycle after reset release; an A request is granted immediately.
